// File: rtl/mcp3202_spi_responder_pkg.sv
// Shared types and constants for the MCP3202 responder: FSM states, frame field widths, result arithmetic.
// No logic of its own; the result helper is pure combinational arithmetic.
package mcp3202_spi_responder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_CFG,
    S_NULL,
    S_DATA_MSB,
    S_DATA_LSB,
    S_DONE
  } state_t;

  localparam int CFG_BITS         = 3;
  localparam int DATA_BITS        = 12;
  localparam int LSB_TRAILER_BITS = 11;
  localparam int RESULT_W         = DATA_BITS;

  // Differential mode is A-B with A picked by ODD; negative differences clamp to zero.
  function automatic logic [RESULT_W-1:0] calc_result(input logic sgl,
                                                      input logic odd,
                                                      input logic [RESULT_W-1:0] ch0,
                                                      input logic [RESULT_W-1:0] ch1);
    logic [RESULT_W-1:0] a;
    logic [RESULT_W-1:0] b;
    logic [RESULT_W:0]   diff;
    a    = odd ? ch1 : ch0;
    b    = odd ? ch0 : ch1;
    diff = {1'b0, a} - {1'b0, b};
    if (sgl)
      return a;
    if (diff[RESULT_W])
      return '0;
    return diff[RESULT_W-1:0];
  endfunction

endpackage

// File: rtl/mcp3202_spi_responder_if.sv
// SPI pin bundle between an SPI master and the MCP3202 responder.
// Pure wiring: no latency, no flow control beyond the SPI protocol itself.
interface mcp3202_spi_responder_if;
  logic SCK;
  logic CS;
  logic MOSI;
  logic MISO;
  logic MISO_OE;

  modport master (output SCK, output CS, output MOSI, input MISO, input MISO_OE);
  modport slave  (input SCK, input CS, input MOSI, output MISO, output MISO_OE);
endinterface

// File: rtl/mcp3202_spi_responder_spi_pin_sync.sv
// Synchronizes SCK/CS/MOSI into clk and derives SCK and CS edge pulses.
// Latency SYNC_STAGES clk from pin to pulse; no backpressure, edges are single-clk pulses.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic cs,
  input  logic mosi,
  output logic mosi_s,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_rise,
  output logic cs_fall
);

  // Bit order {mosi, cs, sck}; CS resets high so reset release never looks like a frame start.
  localparam logic [2:0] PIN_RST = 3'b010;

  logic [SYNC_STAGES-1:0][2:0] chain;
  logic [1:0]                  prev;
  logic [2:0]                  synced;

  assign synced = chain[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{PIN_RST}};
      prev  <= PIN_RST[1:0];
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], {mosi, cs, sck}};
      prev  <= synced[1:0];
    end
  end

  assign mosi_s   = synced[2];
  assign sck_rise =  synced[0] & ~prev[0];
  assign sck_fall = ~synced[0] &  prev[0];
  assign cs_rise  =  synced[1] & ~prev[1];
  assign cs_fall  = ~synced[1] &  prev[1];

endmodule

// File: rtl/mcp3202_spi_responder.sv
// MCP3202 ADC SPI slave emulation; MISO follows a pin SCK fall within SYNC_STAGES+1 clk, no backpressure.
// Define MCP3202_LSBF_EN to enable the LSB-first trailer when the master requests MSBF=0.
module mcp3202_spi_responder
  import mcp3202_spi_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit IDLE_MISO   = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mcp3202_spi_responder_if.slave       spi,
  input  logic [DATA_BITS-1:0]         ch0_data,
  input  logic [DATA_BITS-1:0]         ch1_data,
  output logic                         cfg_sgl,
  output logic                         cfg_odd,
  output logic                         cfg_msbf,
  output logic                         sample_strobe,
  output logic                         xfer_done,
  output logic                         frame_err
);

`ifdef MCP3202_LSBF_EN
  localparam bit LSBF_EN = 1'b1;
`else
  localparam bit LSBF_EN = 1'b0;
`endif

  logic mosi_s;
  logic sck_rise;
  logic sck_fall;
  logic cs_rise;
  logic cs_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sck      (spi.SCK),
    .cs       (spi.CS),
    .mosi     (spi.MOSI),
    .mosi_s   (mosi_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall)
  );

  state_t               state;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 miso_q;
  logic                 miso_oe_q;

  assign spi.MISO    = miso_q;
  assign spi.MISO_OE = miso_oe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      cfg_sgl       <= 1'b0;
      cfg_odd       <= 1'b0;
      cfg_msbf      <= 1'b0;
      sample_strobe <= 1'b0;
      xfer_done     <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      xfer_done     <= 1'b0;
      frame_err     <= 1'b0;
      // CS release outranks any SCK edge arriving in the same cycle.
      if (cs_rise && state != S_IDLE) begin
        state     <= S_IDLE;
        miso_oe_q <= 1'b0;
        miso_q    <= IDLE_MISO;
        xfer_done <= (state == S_DONE);
        frame_err <= (state == S_CFG) || (state == S_NULL) ||
                     (state == S_DATA_MSB) || (state == S_DATA_LSB);
      end else begin
        case (state)
          S_IDLE: begin
            if (cs_fall) begin
              state     <= S_WAIT_START;
              miso_oe_q <= 1'b1;
              miso_q    <= IDLE_MISO;
            end
          end
          S_WAIT_START: begin
            if (sck_rise && mosi_s) begin
              state   <= S_CFG;
              bit_cnt <= '0;
            end
          end
          S_CFG: begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd0) begin
                cfg_sgl <= mosi_s;
              end else if (bit_cnt == 4'd1) begin
                cfg_odd <= mosi_s;
              end else if (bit_cnt == 4'(CFG_BITS - 1)) begin
                cfg_msbf      <= mosi_s;
                shreg         <= calc_result(cfg_sgl, cfg_odd, ch0_data, ch1_data);
                sample_strobe <= 1'b1;
                state         <= S_NULL;
              end
            end
          end
          S_NULL: begin
            if (sck_fall) begin
              miso_q  <= 1'b0;
              bit_cnt <= '0;
              state   <= S_DATA_MSB;
            end
          end
          S_DATA_MSB: begin
            // Rotate rather than shift so the result is intact for the LSB-first trailer.
            if (sck_fall) begin
              miso_q  <= shreg[DATA_BITS-1];
              shreg   <= {shreg[DATA_BITS-2:0], shreg[DATA_BITS-1]};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
                state   <= (cfg_msbf || !LSBF_EN) ? S_DONE : S_DATA_LSB;
              end
            end
          end
          S_DATA_LSB: begin
            if (sck_fall) begin
              miso_q  <= shreg[1];
              shreg   <= {shreg[0], shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'(LSB_TRAILER_BITS - 1))
                state <= S_DONE;
            end
          end
          S_DONE: begin
            if (sck_fall)
              miso_q <= IDLE_MISO;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcp3202_spi_responder.sv
// Directed and randomized SPI frames against a behavioural MCP3202 reference model.
module tb_mcp3202_spi_responder;

  localparam int SYNC_STAGES = 2;
  localparam bit IDLE_MISO   = 1'b0;
`ifdef MCP3202_LSBF_EN
  localparam bit LSBF = 1'b1;
`else
  localparam bit LSBF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] ch0 = '0;
  logic [11:0] ch1 = '0;
  logic        cfg_sgl, cfg_odd, cfg_msbf, sample_strobe, xfer_done, frame_err;

  int ncmp = 0;
  int nfail = 0;
  int n_strobe = 0;
  int n_done = 0;
  int n_err = 0;

  mcp3202_spi_responder_if spi_bus ();

  mcp3202_spi_responder #(.SYNC_STAGES(SYNC_STAGES), .IDLE_MISO(IDLE_MISO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi           (spi_bus),
    .ch0_data      (ch0),
    .ch1_data      (ch1),
    .cfg_sgl       (cfg_sgl),
    .cfg_odd       (cfg_odd),
    .cfg_msbf      (cfg_msbf),
    .sample_strobe (sample_strobe),
    .xfer_done     (xfer_done),
    .frame_err     (frame_err)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (sample_strobe === 1'b1) n_strobe++;
    if (xfer_done === 1'b1)     n_done++;
    if (frame_err === 1'b1)     n_err++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: single-ended picks a channel, differential is a clamped A-B.
  function automatic logic [11:0] model(input bit sgl, input bit odd,
                                        input logic [11:0] c0, input logic [11:0] c1);
    int a, b;
    a = odd ? int'(c1) : int'(c0);
    b = odd ? int'(c0) : int'(c1);
    if (sgl) return 12'(a);
    if (a - b < 0) return 12'd0;
    return 12'(a - b);
  endfunction

  task automatic sck_cycle(input bit mosi, input int h, output logic miso);
    spi_bus.MOSI = mosi;
    repeat (h) @(posedge clk);
    #1 miso = spi_bus.MISO;
    spi_bus.SCK = 1'b1;
    repeat (h) @(posedge clk);
    #1 spi_bus.SCK = 1'b0;
  endtask

  task automatic frame(input int nlead, input bit sgl, input bit odd, input bit msbf,
                       input logic [11:0] c0, input logic [11:0] c1,
                       input int ncyc, input int h, input bit scramble);
    logic        rx [64];
    logic [11:0] r, got_d;
    logic [10:0] got_tr, exp_tr;
    int          s0, d0, e0, cmd_len, done_len, idle_bad;
    bit          mb, exp_done, exp_err;
    r        = model(sgl, odd, c0, c1);
    cmd_len  = nlead + 4;
    done_len = (LSBF && !msbf) ? nlead + 27 : nlead + 16;
    s0 = n_strobe; d0 = n_done; e0 = n_err;
    ch0 = c0; ch1 = c1;
    spi_bus.CS = 1'b0;
    repeat (h) @(posedge clk);
    #1;
    for (int k = 0; k < ncyc; k++) begin
      if (k < nlead)           mb = 1'b0;
      else if (k == nlead)     mb = 1'b1;
      else if (k == nlead + 1) mb = sgl;
      else if (k == nlead + 2) mb = odd;
      else if (k == nlead + 3) mb = msbf;
      else                     mb = bit'($urandom_range(0, 1));
      sck_cycle(mb, h, rx[k]);
      if (scramble && k == nlead + 3) begin
        ch0 = 12'($urandom);
        ch1 = 12'($urandom);
      end
    end
    repeat (h) @(posedge clk);
    #1 spi_bus.CS = 1'b1;
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1 chk("miso_oe_off_after_cs", spi_bus.MISO_OE, 0);
    repeat (h) @(posedge clk);
    #1;
    idle_bad = 0;
    for (int k = 0; k < ncyc && k < cmd_len; k++)
      if (rx[k] !== IDLE_MISO) idle_bad++;
    chk("cmd_phase_idle_miso", idle_bad, 0);
    if (ncyc >= cmd_len) begin
      chk("cfg_sgl", cfg_sgl, sgl);
      chk("cfg_odd", cfg_odd, odd);
      chk("cfg_msbf", cfg_msbf, msbf);
    end
    exp_done = (ncyc >= done_len);
    exp_err  = !exp_done && (ncyc > nlead);
    chk("sample_strobe_count", n_strobe - s0, (ncyc >= cmd_len) ? 1 : 0);
    chk("xfer_done_count", n_done - d0, exp_done ? 1 : 0);
    chk("frame_err_count", n_err - e0, exp_err ? 1 : 0);
    if (ncyc == nlead + 28) begin
      for (int i = 0; i < 12; i++) got_d[11 - i] = rx[nlead + 5 + i];
      for (int i = 0; i < 11; i++) got_tr[i] = rx[nlead + 17 + i];
      exp_tr = (LSBF && !msbf) ? r[11:1] : {11{IDLE_MISO}};
      chk("null_bit", rx[cmd_len], 0);
      chk("result_msb_first", got_d, r);
      chk("lsb_trailer", got_tr, exp_tr);
    end
  endtask

  initial begin
    logic        dummy;
    int          e0, nl, cut, hh;
    bit          rs, ro, rm;
    logic [11:0] rc0, rc1;
    spi_bus.SCK = 1'b0; spi_bus.CS = 1'b1; spi_bus.MOSI = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_miso", spi_bus.MISO, 0);
    chk("reset_miso_oe", spi_bus.MISO_OE, 0);
    chk("reset_cfg", {cfg_sgl, cfg_odd, cfg_msbf}, 0);
    chk("reset_strobes", {sample_strobe, xfer_done, frame_err}, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("idle_miso_oe", spi_bus.MISO_OE, 0);

    // Single-ended CH0 at ~893 kHz SCK.
    frame(0, 1, 0, 1, 12'hA5C, 12'h3C3, 28, 70, 1);
    // Differential: negative clamps to zero, then reversed polarity.
    frame(0, 0, 0, 1, 12'h100, 12'h200, 28, 8, 0);
    frame(0, 0, 1, 1, 12'h100, 12'h200, 28, 8, 0);
    // Leading zeros before the start bit.
    frame(3, 1, 1, 1, 12'h000, 12'hFFF, 31, 8, 1);
    // CS released after five data bits.
    frame(0, 1, 0, 1, 12'h5A5, 12'h000, 10, 8, 0);
    // LSB-first request.
    frame(0, 1, 0, 0, 12'h801, 12'h123, 28, 8, 0);
    // CS released during leading zeros: neither pulse.
    frame(3, 1, 0, 1, 12'h111, 12'h222, 2, 8, 0);

    // Reset asserted in the middle of the MSB data phase.
    e0 = n_err;
    ch0 = 12'h9C3;
    spi_bus.CS = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++)
      sck_cycle((k == 0 || k == 1 || k == 3) ? 1'b1 : 1'b0, 8, dummy);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_miso_oe", spi_bus.MISO_OE, 0);
    chk("midreset_outputs",
        {spi_bus.MISO, cfg_sgl, cfg_odd, cfg_msbf, sample_strobe, xfer_done, frame_err}, 0);
    spi_bus.CS = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("midreset_no_frame_err", n_err - e0, 0);
    frame(1, 1, 0, 1, 12'h9C3, 12'h456, 29, 8, 0);

    for (int it = 0; it < 14; it++) begin
      nl  = int'($urandom_range(0, 3));
      rs  = bit'($urandom_range(0, 1));
      ro  = bit'($urandom_range(0, 1));
      rm  = bit'($urandom_range(0, 1));
      rc0 = 12'($urandom);
      rc1 = 12'($urandom);
      hh  = int'($urandom_range(5, 10));
      cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, nl + 27)) : nl + 28;
      frame(nl, rs, ro, rm, rc0, rc1, cut, hh, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
